// File: rtl/mux_nway_pipe.sv
// mux_nway_pipe
//   Registered N-input, WIDTH-bit selector with valid/ready handshakes on both
//   sides and a 2-entry skid buffer. It is meant for wide operand/result
//   selection between pipeline stages, for example choosing an ALU source or
//   a write-back source. Back-pressure never drops or duplicates a word.
//
// Parameters
//   WIDTH     data word width (>= 1)
//   NUM_IN    number of data inputs (>= 2)
//   SEL_W     select width, derived from NUM_IN; leave at its default
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   data_in    packed inputs; input i sits at data_in[i*WIDTH +: WIDTH]
//   sel        input index, sampled together with data_in
//   in_valid   upstream is offering {data_in, sel}
//   in_ready   block can accept this cycle (decoded from registered state only)
//   data_out   selected word at the head of the buffer
//   sel_err    head word was produced by an out-of-range sel
//   out_valid  data_out / sel_err hold a valid word
//   out_ready  downstream consumes the head word this cycle
//
// States
//   EMPTY | no words held, out_valid=0
//   ONE   | main register holds the head word
//   TWO   | main holds the head word, skid holds the next one, in_ready=0

module mux_nway_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        data_out,
  output logic                    sel_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   main_data;
  logic               main_err;
  logic [WIDTH-1:0]   skid_data;
  logic               skid_err;

  logic [WIDTH-1:0]   pick_data;
  logic               pick_err;
  logic               accept;
  logic               pop;

  // Out-of-range selects (only reachable when NUM_IN is not a power of two)
  // resolve to a zero word flagged with an error rather than wrapping around.
  always_comb begin
    pick_data = '0;
    pick_err  = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        pick_data = data_in[i*WIDTH +: WIDTH];
        pick_err  = 1'b0;
      end
    end
  end

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign data_out  = main_data;
  assign sel_err   = main_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      main_data <= '0;
      main_err  <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_data <= pick_data;
            main_err  <= pick_err;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_data <= pick_data;
            main_err  <= pick_err;
          end else if (accept) begin
            // Head is stalled; park the newcomer behind it.
            skid_data <= pick_data;
            skid_err  <= pick_err;
            state     <= TWO;
          end else if (pop) begin
            state     <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            main_data <= skid_data;
            main_err  <= skid_err;
            state     <= ONE;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_nway_pipe.sv
module tb_mux_nway_pipe;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  // DUT A: WIDTH=32, NUM_IN=4 (streaming, stall, simultaneous, reset)
  logic [127:0] d4;
  logic [1:0]   s4;
  logic         iv4, ir4, ov4, or4, e4;
  logic [31:0]  do4;

  // DUT B: WIDTH=8, NUM_IN=3 (bad select)
  logic [23:0]  d3;
  logic [1:0]   s3;
  logic         iv3, ir3, ov3, or3, e3;
  logic [7:0]   do3;

  // DUT C: WIDTH=1, NUM_IN=2 (random)
  logic [1:0]   d1;
  logic [0:0]   s1;
  logic         iv1, ir1, ov1, or1, e1;
  logic [0:0]   do1;

  // DUT D: WIDTH=32, NUM_IN=5 (random)
  logic [159:0] d5;
  logic [2:0]   s5;
  logic         iv5, ir5, ov5, or5, e5;
  logic [31:0]  do5;

  mux_nway_pipe #(.WIDTH(32), .NUM_IN(4)) u4 (
    .clk(clk), .reset(reset), .data_in(d4), .sel(s4), .in_valid(iv4),
    .in_ready(ir4), .data_out(do4), .sel_err(e4), .out_valid(ov4), .out_ready(or4));

  mux_nway_pipe #(.WIDTH(8), .NUM_IN(3)) u3 (
    .clk(clk), .reset(reset), .data_in(d3), .sel(s3), .in_valid(iv3),
    .in_ready(ir3), .data_out(do3), .sel_err(e3), .out_valid(ov3), .out_ready(or3));

  mux_nway_pipe #(.WIDTH(1), .NUM_IN(2)) u1 (
    .clk(clk), .reset(reset), .data_in(d1), .sel(s1), .in_valid(iv1),
    .in_ready(ir1), .data_out(do1), .sel_err(e1), .out_valid(ov1), .out_ready(or1));

  mux_nway_pipe #(.WIDTH(32), .NUM_IN(5)) u5 (
    .clk(clk), .reset(reset), .data_in(d5), .sel(s5), .in_valid(iv5),
    .in_ready(ir5), .data_out(do5), .sel_err(e5), .out_valid(ov5), .out_ready(or5));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One table row: stimulus for the cycle and the expected outputs after the edge.
  typedef struct {
    logic        iv;
    logic [1:0]  sel;
    logic [31:0] word;
    logic        ordy;
    logic        ev;
    logic        er;
    logic [31:0] ed;
  } row_t;

  row_t rows[16];

  // Drives the row (selected input carries the word, the others carry junk),
  // then checks the outputs just after the next rising edge.
  task automatic apply_row(input int idx);
    row_t r;
    r = rows[idx];
    for (int i = 0; i < 4; i++)
      d4[i*32 +: 32] = (i == int'(r.sel)) ? r.word : (32'hDEAD_0000 + 32'(i));
    s4  = r.sel;
    iv4 = r.iv;
    or4 = r.ordy;
    @(posedge clk);
    #1;
    chk($sformatf("row%0d_out_valid", idx), 64'(ov4), 64'(r.ev));
    chk($sformatf("row%0d_in_ready", idx), 64'(ir4), 64'(r.er));
    if (r.ev) begin
      chk($sformatf("row%0d_data_out", idx), 64'(do4), 64'(r.ed));
      chk($sformatf("row%0d_sel_err", idx), 64'(e4), 64'd0);
    end
  endtask

  // Scoreboard entries hold {err, data}.
  logic [32:0] q1[$];
  logic [32:0] q5[$];

  initial begin
    n_cmp = 0;
    n_err = 0;

    //           iv    sel   word          ordy  ev    er    ed
    // streaming, one word per clock
    rows[0]  = '{1'b1, 2'd0, 32'h0000_00A0, 1'b1, 1'b1, 1'b1, 32'h0000_00A0};
    rows[1]  = '{1'b1, 2'd1, 32'h0000_00A1, 1'b1, 1'b1, 1'b1, 32'h0000_00A1};
    rows[2]  = '{1'b1, 2'd2, 32'h0000_00A2, 1'b1, 1'b1, 1'b1, 32'h0000_00A2};
    rows[3]  = '{1'b1, 2'd3, 32'h0000_00A3, 1'b1, 1'b1, 1'b1, 32'h0000_00A3};
    rows[4]  = '{1'b0, 2'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0000};
    // stall: two words accepted, a third offered but refused, then drain
    rows[5]  = '{1'b1, 2'd2, 32'h0000_00C2, 1'b0, 1'b1, 1'b1, 32'h0000_00C2};
    rows[6]  = '{1'b1, 2'd1, 32'h0000_00B1, 1'b0, 1'b1, 1'b0, 32'h0000_00C2};
    rows[7]  = '{1'b1, 2'd3, 32'h0000_00DD, 1'b0, 1'b1, 1'b0, 32'h0000_00C2};
    rows[8]  = '{1'b0, 2'd0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h0000_00B1};
    rows[9]  = '{1'b0, 2'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0000};
    // simultaneous accept and pop while holding one word
    rows[10] = '{1'b1, 2'd0, 32'h0000_0011, 1'b0, 1'b1, 1'b1, 32'h0000_0011};
    rows[11] = '{1'b1, 2'd3, 32'h0000_0033, 1'b1, 1'b1, 1'b1, 32'h0000_0033};
    rows[12] = '{1'b0, 2'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0000};
    // fill to two entries before the asynchronous reset
    rows[13] = '{1'b1, 2'd0, 32'h0000_0044, 1'b0, 1'b1, 1'b1, 32'h0000_0044};
    rows[14] = '{1'b1, 2'd1, 32'h0000_0055, 1'b0, 1'b1, 1'b0, 32'h0000_0044};
    // first accept right after reset release
    rows[15] = '{1'b1, 2'd2, 32'h0000_0066, 1'b1, 1'b1, 1'b1, 32'h0000_0066};

    reset = 1'b1;
    d4 = '0; s4 = '0; iv4 = 1'b0; or4 = 1'b0;
    d3 = '0; s3 = '0; iv3 = 1'b0; or3 = 1'b0;
    d1 = '0; s1 = '0; iv1 = 1'b0; or1 = 1'b0;
    d5 = '0; s5 = '0; iv5 = 1'b0; or5 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    chk("rst_out_valid", 64'(ov4), 64'd0);
    chk("rst_in_ready", 64'(ir4), 64'd1);
    chk("rst_data_out", 64'(do4), 64'd0);
    chk("rst_sel_err", 64'(e4), 64'd0);

    for (int i = 0; i <= 14; i++) apply_row(i);

    // Asynchronous reset in the middle of the TWO state, checked between edges.
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(ov4), 64'd0);
    chk("async_rst_in_ready", 64'(ir4), 64'd1);
    chk("async_rst_data_out", 64'(do4), 64'd0);
    chk("async_rst_sel_err", 64'(e4), 64'd0);
    #1;
    reset = 1'b0;
    apply_row(15);
    iv4 = 1'b0;

    // Bad select on a 3-input instance.
    d3  = {8'h33, 8'h22, 8'h11};
    or3 = 1'b1;
    iv3 = 1'b1;
    s3  = 2'd3;
    @(posedge clk);
    #1;
    chk("badsel_out_valid", 64'(ov3), 64'd1);
    chk("badsel_data_out", 64'(do3), 64'd0);
    chk("badsel_sel_err", 64'(e3), 64'd1);
    s3 = 2'd0;
    @(posedge clk);
    #1;
    chk("sel0_data_out", 64'(do3), 64'h11);
    chk("sel0_sel_err", 64'(e3), 64'd0);
    s3 = 2'd2;
    @(posedge clk);
    #1;
    chk("sel2_data_out", 64'(do3), 64'h33);
    chk("sel2_sel_err", 64'(e3), 64'd0);
    iv3 = 1'b0;
    @(posedge clk);
    #1;
    chk("badsel_drain_valid", 64'(ov3), 64'd0);

    // Random traffic against a FIFO scoreboard with capacity two.
    for (int c = 0; c < 10000; c++) begin
      logic        acc1, pop1, acc5, pop5;
      logic [32:0] w1, w5;
      logic [159:0] sh;

      iv1 = ($urandom_range(0, 9) < 6);
      or1 = ($urandom_range(0, 9) < 6);
      d1  = 2'($urandom);
      s1  = 1'($urandom_range(0, 1));
      iv5 = ($urandom_range(0, 9) < 6);
      or5 = ($urandom_range(0, 9) < 5);
      for (int k = 0; k < 5; k++) d5[k*32 +: 32] = $urandom;
      s5  = 3'($urandom_range(0, 7));

      chk("rnd_w1_out_valid", 64'(ov1), 64'(q1.size() != 0));
      chk("rnd_w1_in_ready", 64'(ir1), 64'(q1.size() < 2));
      if (q1.size() != 0) begin
        chk("rnd_w1_data_out", 64'(do1), 64'(q1[0][0]));
        chk("rnd_w1_sel_err", 64'(e1), 64'(q1[0][32]));
      end
      chk("rnd_n5_out_valid", 64'(ov5), 64'(q5.size() != 0));
      chk("rnd_n5_in_ready", 64'(ir5), 64'(q5.size() < 2));
      if (q5.size() != 0) begin
        chk("rnd_n5_data_out", 64'(do5), 64'(q5[0][31:0]));
        chk("rnd_n5_sel_err", 64'(e5), 64'(q5[0][32]));
      end

      acc1 = iv1 && (q1.size() < 2);
      pop1 = or1 && (q1.size() != 0);
      w1   = {1'b0, 31'd0, d1[s1]};

      acc5 = iv5 && (q5.size() < 2);
      pop5 = or5 && (q5.size() != 0);
      if (int'(s5) < 5) begin
        sh = d5 >> (32 * int'(s5));
        w5 = {1'b0, sh[31:0]};
      end else begin
        w5 = {1'b1, 32'd0};
      end

      @(posedge clk);
      #1;
      if (pop1) void'(q1.pop_front());
      if (acc1) q1.push_back(w1);
      if (pop5) void'(q5.pop_front());
      if (acc5) q5.push_back(w5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
